pipeline_hazard_ctrl: RTL

Sequencing controller for the five-stage MIPS pipeline. It sits beside the decode stage and drives the write-enables, flushes and bubble inserts of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three event types in fixed priority: data-memory wait, load-use hazard, then taken branch. A memory wait that never ends halts the pipeline permanently until reset.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/load_use_detect.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline sequencing logic: FSM states and register indices.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_e;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator; also shared with the forwarding unit.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic     mem_read_i,
    input  reg_idx_t ex_rt_i,
    input  reg_idx_t id_rs_i,
    input  reg_idx_t id_rt_i,
    input  logic     id_uses_rt_i,
    output logic     lu_o
);

    // A load targeting $zero never produces a real value, so it cannot cause a hazard.
    assign lu_o = mem_read_i && (ex_rt_i != ZERO_REG) &&
                  ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the five-stage pipeline: memory wait, load-use, branch flush.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDExReadMemoryEnable,
    input  logic [4:0]       IDExRt,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IFIDUsesRt,
    input  logic             BranchTaken,
    input  logic             MemBusy,
    output logic             PcWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDExBubble,
    output logic             PipeFreeze,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    state_e            state_q, state_d, cur_state;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              lu;
    logic              freeze_all;

    load_use_detect u_lu (
        .mem_read_i   (IDExReadMemoryEnable),
        .ex_rt_i      (IDExRt),
        .id_rs_i      (IFIDRs),
        .id_rt_i      (IFIDRt),
        .id_uses_rt_i (IFIDUsesRt),
        .lu_o         (lu)
    );

    // Outputs decode as RUN while reset is held.
    assign cur_state = rst ? RUN : state_q;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        freeze_all = 1'b0;
        case (cur_state)
            RUN: begin
                freeze_all = MemBusy;
                if (MemBusy) begin
                    wait_d  = WAIT_W'(1);
                    state_d = MEMWAIT;
                end
            end
            MEMWAIT: begin
                freeze_all = MemBusy;
                if (!MemBusy) begin
                    wait_d  = '0;
                    state_d = RUN;
                end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    state_d = HALT;
                end
            end
            default: freeze_all = 1'b1;
        endcase
    end

    always_comb begin
        PcWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IFIDFlush  = 1'b0;
        IDExBubble = 1'b0;
        PipeFreeze = 1'b0;
        Halted     = (cur_state == HALT);
        if (freeze_all) begin
            PipeFreeze = 1'b1;
        end else if (lu) begin
            // IF/ID holds, so a simultaneous branch re-resolves next cycle.
            IDExBubble = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush = 1'b1;
            PcWrite   = 1'b1;
        end else begin
            PcWrite   = 1'b1;
            IFIDWrite = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!PcWrite && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (IFIDFlush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
